// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: the I-memory request/grant/response channel plus the
// instruction valid/ready channel and the redirect inputs from the core.
interface inst_fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch queue: sequential word fetches, byte-swap, PC-tagged FIFO, redirect flush.
// Optional performance counters are enabled with INST_FETCH_QUEUE_PERF_EN.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  rst_n,
    inst_fetch_queue_if.master   bus
`ifdef INST_FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_flushed
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [31:0]       r_fetchPc;
    logic [31:0]       r_pendPc;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [31:0]       r_instMem [DEPTH];
    logic [31:0]       r_pcMem   [DEPTH];

    logic              w_memReq;
    logic              w_grant;
    logic              w_push;
    logic              w_pop;
    logic              w_credit;
    logic [CNT_W:0]    w_used;
    logic [31:0]       w_swapped;
    logic              w_unused;

    // An outstanding request reserves a slot, so a response never meets a full queue
    assign w_used    = {1'b0, r_count} + {{CNT_W{1'b0}}, (r_state != IDLE)};
    assign w_credit  = w_used < (CNT_W+1)'(DEPTH);
    assign w_grant   = w_memReq && bus.mem_gnt;
    assign w_push    = (r_state == WAIT) && bus.mem_rvalid && !bus.redirect_valid;
    assign w_pop     = bus.inst_valid && bus.inst_ready;
    assign w_swapped = {bus.mem_rdata[7:0], bus.mem_rdata[15:8],
                        bus.mem_rdata[23:16], bus.mem_rdata[31:24]};
    assign w_unused  = ^bus.redirect_pc[1:0];

    assign bus.mem_addr   = r_fetchPc;
    assign bus.inst_valid = (r_count != '0);
    assign bus.inst       = r_instMem[r_rdPtr];
    assign bus.inst_pc    = r_pcMem[r_rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A redirect turns an in-flight request into one whose response is thrown away
    always_comb begin
        w_nextState = r_state;
        if (bus.redirect_valid) begin
            if (bus.mem_rvalid) begin
                w_nextState = IDLE;
            end else if (r_state != IDLE) begin
                w_nextState = DROP;
            end
        end else begin
            case (r_state)
                IDLE:       if (w_grant) w_nextState = WAIT;
                WAIT, DROP: if (bus.mem_rvalid) w_nextState = IDLE;
                default:    w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        w_memReq = rst_n && (r_state == IDLE) && w_credit && !bus.redirect_valid;
    end

    assign bus.mem_req = w_memReq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchPc <= RESET_PC;
            r_pendPc  <= '0;
            r_count   <= '0;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instMem[i] <= '0;
                r_pcMem[i]   <= '0;
            end
        end else if (bus.redirect_valid) begin
            r_fetchPc <= {bus.redirect_pc[31:2], 2'b00};
            r_count   <= '0;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
        end else begin
            if (w_grant) begin
                r_pendPc  <= r_fetchPc;
                r_fetchPc <= r_fetchPc + 32'd4;
            end
            if (w_push) begin
                r_instMem[r_wrPtr] <= w_swapped;
                r_pcMem[r_wrPtr]   <= r_pendPc;
                r_wrPtr            <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifdef INST_FETCH_QUEUE_PERF_EN
    logic w_flushEvent;
    assign w_flushEvent = bus.redirect_valid &&
                          ((r_count != '0) || ((r_state == WAIT) && !bus.mem_rvalid));

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (w_grant && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (w_flushEvent && (perf_flushed != 32'hFFFF_FFFF)) begin
                perf_flushed <= perf_flushed + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a latency-programmable memory responder
// queues the expected {instruction, PC} pairs and the consumer side pops and compares.
module tb_inst_fetch_queue;
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic clk = 1'b0;
    logic rstN = 1'b1;

    inst_fetch_queue_if bus ();

`ifdef INST_FETCH_QUEUE_PERF_EN
    logic [31:0] perfFetched;
    logic [31:0] perfFlushed;
`endif

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (bus)
`ifdef INST_FETCH_QUEUE_PERF_EN
        ,
        .perf_fetched (perfFetched),
        .perf_flushed (perfFlushed)
`endif
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nFails  = 0;
    entry_t      expQ[$];
    logic [31:0] modelPc = 32'h0;
    bit          pendActive = 0;
    bit          pendOwned  = 0;
    bit          pendKeep   = 0;
    bit          pendConst  = 0;
    int          pendCnt    = 0;
    logic [31:0] pendAddr   = 32'h0;
    bit          useConst   = 1;
    int          memLat     = 1;

    function automatic logic [31:0] instOf(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h8765_4313;
    endfunction

    function automatic logic [31:0] swapOf(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic boundExpired(input string tag);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: cycle budget expired at %0t", tag, $time);
    endtask

    // One clock cycle: drive inputs at the falling edge, check, update the model, advance
    task automatic applyStimulus(input bit gnt, input bit ready, input bit redir,
                                 input logic [31:0] redirPc);
        bit     rvNow;
        bit     expReq;
        bit     grant;
        entry_t e;
        rvNow = 0;
        if (pendActive) begin
            pendCnt--;
            if (pendCnt == 0) rvNow = 1;
        end
        bus.mem_gnt        = gnt;
        bus.inst_ready     = ready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redirPc;
        bus.mem_rvalid     = rvNow;
        bus.mem_rdata      = !rvNow ? 32'h0 : (pendConst ? 32'h1300_0000 : swapOf(instOf(pendAddr)));
        #1;
        checkOutput("inst_valid", {31'h0, bus.inst_valid}, {31'h0, expQ.size() != 0});
        if (expQ.size() != 0) begin
            checkOutput("inst", bus.inst, expQ[0].inst);
            checkOutput("inst_pc", bus.inst_pc, expQ[0].pc);
        end
        expReq = !pendOwned && (expQ.size() < 4) && !redir;
        checkOutput("mem_req", {31'h0, bus.mem_req}, {31'h0, expReq});
        checkOutput("mem_addr", bus.mem_addr, modelPc);
        grant = expReq && gnt;
        if ((expQ.size() != 0) && ready) void'(expQ.pop_front());
        if (rvNow) begin
            pendActive = 0;
            if (pendOwned && pendKeep && !redir) begin
                e.inst = pendConst ? 32'h0000_0013 : instOf(pendAddr);
                e.pc   = pendAddr;
                expQ.push_back(e);
            end
            pendOwned = 0;
        end
        if (redir) begin
            expQ.delete();
            pendKeep = 0;
            modelPc  = {redirPc[31:2], 2'b00};
        end else if (grant) begin
            pendActive = 1;
            pendOwned  = 1;
            pendKeep   = 1;
            pendConst  = useConst;
            pendCnt    = memLat;
            pendAddr   = modelPc;
            modelPc    = modelPc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        bus.inst_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        #1 rstN = 1'b0;
        @(negedge clk); @(negedge clk);
        checkOutput("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        checkOutput("rst_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
        checkOutput("rst_inst", bus.inst, 32'h0);
        checkOutput("rst_inst_pc", bus.inst_pc, 32'h0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        rstN = 1'b1;

        // Fill the queue with no consumer; credit must stop requests at four entries
        useConst = 1; memLat = 1;
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("creditStop", {31'h0, bus.mem_req}, 32'h0);

        // A single pop frees exactly one slot
        applyStimulus(1, 1, 0, 0);
        checkOutput("reqAfterPop", {31'h0, bus.mem_req}, 32'h1);
        checkOutput("addrAfterPop", bus.mem_addr, 32'h0000_0010);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);

        // Grant withheld: request and address must hold
        useConst = 0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        memLat = 3;
        applyStimulus(1, 0, 0, 0);

        // Redirect held two cycles while WAIT; the late response is dropped
        applyStimulus(1, 1, 1, 32'h0000_00F0);
        applyStimulus(1, 1, 1, 32'h0000_0103);
        applyStimulus(1, 1, 0, 0);
        checkOutput("redirAddr", bus.mem_addr, 32'h0000_0100);
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);

        // Redirect coinciding with a response while two entries are queued
        memLat = 1;
        applyStimulus(0, 0, 1, 32'h0000_0180);
        guard = 0;
        while (!(pendActive && pendOwned && pendKeep && pendCnt == 1 && expQ.size() == 2)
               && guard < 20) begin
            applyStimulus(1, 0, 0, 0);
            guard++;
        end
        if (guard >= 20) boundExpired("syncRedirRv");
        applyStimulus(1, 0, 1, 32'h0000_0200);
        checkOutput("flushValid", {31'h0, bus.inst_valid}, 32'h0);
        checkOutput("flushAddr", bus.mem_addr, 32'h0000_0200);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);

        // Address wrap at the top of memory, then reset while a request is outstanding
        memLat = 3;
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC);
        guard = 0;
        while (modelPc != 32'h0 && guard < 10) begin
            applyStimulus(1, 0, 0, 0);
            guard++;
        end
        if (guard >= 10) boundExpired("wrapGrant");
        checkOutput("wrapAddr", bus.mem_addr, 32'h0);
        guard = 0;
        while (modelPc != 32'h4 && guard < 10) begin
            applyStimulus(1, 0, 0, 0);
            guard++;
        end
        if (guard >= 10) boundExpired("postWrapGrant");
        #2 rstN = 1'b0;
        #1;
        checkOutput("asyncRst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        checkOutput("asyncRst_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
        checkOutput("asyncRst_inst", bus.inst, 32'h0);
        checkOutput("asyncRst_inst_pc", bus.inst_pc, 32'h0);
        checkOutput("asyncRst_mem_addr", bus.mem_addr, 32'h0);
        expQ.delete();
        pendOwned = 0;
        pendKeep  = 0;
        modelPc   = 32'h0;
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch front end between I-memory and the RISC-V core's decode.
- Issues sequential word fetches over a request/grant/response handshake and byte-swaps returned words into instruction order.
- Buffers up to DEPTH instructions, each tagged with its PC, and presents them to the core with a valid/ready handshake.
- Flushes and restarts on a redirect (taken branch, jal, jalr) from the core.

Parameters:
- DEPTH, 4, queue entries; power of two, range 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- mem_req  output  1  fetch request valid.
- mem_addr  output  32  fetch word address; bits [1:0] always 0.
- mem_gnt  input  1  memory accepts the request this cycle when high together with mem_req.
- mem_rvalid  input  1  response data valid; at most one response per granted request, 1 or more cycles after grant.
- mem_rdata  input  32  response word as stored in memory (byte-reversed relative to instruction order).
- inst_valid  output  1  queue head holds an instruction.
- inst  output  32  head instruction, byte-swapped: {rdata[7:0],rdata[15:8],rdata[23:16],rdata[31:24]}.
- inst_pc  output  32  PC of the head instruction.
- inst_ready  input  1  core consumes the head this cycle when high together with inst_valid.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  32  restart address; bits [1:0] ignored, treated as 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, fetch_pc=RESET_PC, count=0, read/write pointers=0.
  - mem_req=0, inst_valid=0, inst/inst_pc=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: one granted request outstanding; its response will be kept.
  - DROP: one granted request outstanding; its response will be discarded.
- Credit rule: a new request is allowed only if count + (state!=IDLE) < DEPTH, so a response can never arrive to a full queue.
- mem_req (combinational): state==IDLE && credit && !redirect_valid.
- mem_addr = fetch_pc.
- Grant (mem_req && mem_gnt): state IDLE->WAIT; mem_addr is latched as the pending PC; fetch_pc <= fetch_pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- mem_req held without mem_gnt: the request stays high and mem_addr stays stable until granted.
- Response in WAIT (mem_rvalid, no redirect):
  - Write {swapped rdata, pending PC} at the write pointer; count+1; state->IDLE.
  - The new entry is visible on inst/inst_valid the next cycle, so rvalid-to-inst_valid latency is 1 cycle. No bypass.
  - A new request may be issued in the cycle after the response, not the same cycle.
- Response in DROP: data discarded, state->IDLE.
- mem_rvalid while in IDLE: ignored.
- Pop (inst_valid && inst_ready): read pointer+1, count-1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Redirect (highest priority), taking effect in one cycle:
  - count=0, pointers=0, inst_valid=0 next cycle; fetch_pc <= {redirect_pc[31:2],2'b00}.
  - No grant is taken in the redirect cycle.
  - State transitions: WAIT->DROP; DROP stays DROP; IDLE stays IDLE.
  - A response arriving in the redirect cycle is discarded and state->IDLE (only one response is ever outstanding).
  - A pop in the redirect cycle is still consumed by the core; the flush overrides the pointer update.
- Redirect held for several cycles: fetch_pc tracks the latest redirect_pc; mem_req stays 0.
- Reset asserted mid-transaction: all state clears immediately. Any later mem_rvalid for the lost request arrives in IDLE and is ignored.

Optional Feature:
- Macro: INST_FETCH_QUEUE_PERF_EN.
- When defined:
  - Adds outputs perf_fetched[31:0] (increments on every grant) and perf_flushed[31:0] (increments on each redirect cycle that discards at least one queued entry or moves WAIT->DROP).
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, mem_gnt=1, 1-cycle rvalid, mem_rdata=32'h1300_0000, inst_ready=0 -> mem_addr 0,4,8,12; four entries, inst=32'h0000_0013, inst_pc=0; mem_req=0 once credit is exhausted.
- Queue full with DEPTH=4, then a single pop -> exactly one new request issued, addr=16; mem_req never high while count+outstanding=4.
- mem_gnt held low 3 cycles with mem_req=1 -> mem_addr stable at 0; fetch_pc advances only on the grant cycle.
- Redirect to 32'h0000_0103 while WAIT (response pending, latency 3) -> late response dropped; next mem_addr=32'h0000_0100; inst_valid=0 until the 0x100 data returns; inst_pc=0x100.
- redirect_valid and mem_rvalid in the same cycle, 2 entries queued -> count=0, response discarded, state IDLE; next request at redirect_pc.
- fetch_pc=32'hFFFF_FFFC granted -> next mem_addr=0. Assert rst_n low while WAIT -> outputs clear asynchronously; restart at RESET_PC.
